// File: rtl/eq_pkg.sv
// eq_pkg: shared scan FSM states, pot slot-to-A2D channel map and reset constants
package eq_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} scan_state_e;
  localparam int NUM_SLOTS = 6;
  localparam logic [2:0] CH_LP  = 3'd1;
  localparam logic [2:0] CH_B1  = 3'd0;
  localparam logic [2:0] CH_B2  = 3'd4;
  localparam logic [2:0] CH_B3  = 3'd2;
  localparam logic [2:0] CH_HP  = 3'd3;
  localparam logic [2:0] CH_VOL = 3'd7;
  localparam logic [11:0] POT_UNITY = 12'h800;
  localparam logic [11:0] POT_MUTE  = 12'h000;
  function automatic logic [2:0] slot_chnnl(input logic [2:0] slot);
    return slot == 3'd0 ? CH_LP :
           slot == 3'd1 ? CH_B1 :
           slot == 3'd2 ? CH_B2 :
           slot == 3'd3 ? CH_B3 :
           slot == 3'd4 ? CH_HP : CH_VOL;
  endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter with zero flag; ports clk/rst_n, load+load_val, dec, zero
module scan_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/pot_scan_ctrl.sv
// pot_scan_ctrl: round-robin A2D scheduler for six EQ pots; strt_cnv/chnnl out, cnv_cmplt/res in, *_pot/pots_vld/sweep_done/a2d_err out
module pot_scan_ctrl import eq_pkg::*; #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] VOL_pot,
  output logic        pots_vld,
  output logic        sweep_done,
  output logic        a2d_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);
  scan_state_e state, state_nxt;
  logic [2:0] slot;
  logic [NUM_SLOTS-1:0] seen;
  logic [11:0] pot [NUM_SLOTS];
  logic tmr_load, tmr_dec, tmr_zero, capture, timeout, advance;
  logic [TW-1:0] tmr_val;
  // one counter serves both the conversion watchdog and the inter-conversion gap
  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = TO_LOAD;
    capture   = 1'b0;
    timeout   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE:  state_nxt = START;
      START: begin
        tmr_load  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // completion takes priority over a watchdog expiring in the same cycle
        capture   = cnv_cmplt;
        timeout   = !cnv_cmplt && tmr_zero;
        tmr_load  = cnv_cmplt || tmr_zero;
        tmr_val   = GAP_LOAD;
        tmr_dec   = !tmr_load;
        state_nxt = tmr_load ? GAP : WAIT;
      end
      GAP: begin
        advance   = tmr_zero;
        tmr_dec   = !tmr_zero;
        state_nxt = tmr_zero ? START : GAP;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      slot     <= 3'd0;
      seen     <= '0;
      pots_vld <= 1'b0;
      a2d_err  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) pot[i] <= (i == NUM_SLOTS - 1) ? POT_MUTE : POT_UNITY;
    end else begin
      state    <= state_nxt;
      pots_vld <= &seen;
      if (capture) begin
        pot[slot]  <= res;
        seen[slot] <= 1'b1;
      end
      if (timeout) a2d_err <= 1'b1;
      if (advance) slot <= slot == LAST_SLOT ? 3'd0 : slot + 3'd1;
    end
  assign strt_cnv   = state == START;
  assign chnnl      = slot_chnnl(slot);
  assign sweep_done = advance && slot == LAST_SLOT;
  assign LP_pot     = pot[0];
  assign B1_pot     = pot[1];
  assign B2_pot     = pot[2];
  assign B3_pot     = pot[3];
  assign HP_pot     = pot[4];
  assign VOL_pot    = pot[5];
endmodule

// File: tb/tb_pot_scan_ctrl.sv
// tb_pot_scan_ctrl: randomized A2D responder with a per-conversion transaction model of the pot scanner
module tb_pot_scan_ctrl;
  localparam int G = 16;
  localparam int T = 64;
  logic clk, rst_n, strt_cnv, cnv_cmplt, pots_vld, sweep_done, a2d_err;
  logic [2:0] chnnl;
  logic [11:0] res, LP_pot, B1_pot, B2_pot, B3_pot, HP_pot, VOL_pot;
  logic [71:0] dut_vec;
  int n_tests, n_fail, cyc, mslot, c0, k0;
  int code_tab [6] = '{1, 0, 4, 2, 3, 7};
  logic [11:0] mp [6];
  logic [5:0] mseen;
  logic merr;
  pot_scan_ctrl #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .strt_cnv   (strt_cnv),
    .chnnl      (chnnl),
    .cnv_cmplt  (cnv_cmplt),
    .res        (res),
    .LP_pot     (LP_pot),
    .B1_pot     (B1_pot),
    .B2_pot     (B2_pot),
    .B3_pot     (B3_pot),
    .HP_pot     (HP_pot),
    .VOL_pot    (VOL_pot),
    .pots_vld   (pots_vld),
    .sweep_done (sweep_done),
    .a2d_err    (a2d_err)
  );
  assign dut_vec = {VOL_pot, HP_pot, B3_pot, B2_pot, B1_pot, LP_pot};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [71:0] model_vec();
    return {mp[5], mp[4], mp[3], mp[2], mp[1], mp[0]};
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 5; i++) mp[i] = 12'h800;
    mp[5] = 12'h000;
    mseen = '0;
    merr = 1'b0;
    mslot = 0;
  endtask
  task automatic wait_strt(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!strt_cnv && k < 50);
  endtask
  // entered on the negedge where strt_cnv is seen; returns on the next strt_cnv negedge
  // lat: cycles from strt_cnv to cnv_cmplt (1..T), 0 means the A2D never answers
  task automatic conv(input int lat, input logic [11:0] val, input bit gap_pulse);
    int done, nxt, sd_n, sd_k, k;
    bit vb;
    chk("chnnl", chnnl, code_tab[mslot]);
    done = lat != 0 ? lat : T;
    nxt = 1 + (done - 1) + 1 + G;
    vb = &mseen;
    sd_n = 0;
    sd_k = -1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      cnv_cmplt = 1'b0;
      if (sweep_done) begin
        sd_n++;
        sd_k = k;
      end
      if (lat != 0 && k == lat) begin
        chk("chnnl_hold", chnnl, code_tab[mslot]);
        cnv_cmplt = 1'b1;
        res = val;
      end
      if (lat != 0 && k == lat + 1) begin
        mp[mslot] = val;
        mseen[mslot] = 1'b1;
        chk("pots_cap", dut_vec, model_vec());
        chk("err_cap", a2d_err, merr);
        chk("vld_pre", pots_vld, vb);
      end
      if (lat != 0 && k == lat + 2) chk("vld_post", pots_vld, &mseen);
      if (lat == 0 && k == T) chk("err_pre", a2d_err, merr);
      if (lat == 0 && k == T + 1) begin
        merr = 1'b1;
        chk("err_set", a2d_err, 1'b1);
      end
      if (gap_pulse && k == done + 3) begin
        cnv_cmplt = 1'b1;
        res = 12'hFFF;
      end
      if (k == nxt - 1) chk("pots_hold", dut_vec, model_vec());
    end while (!strt_cnv && k < nxt + 8);
    cnv_cmplt = 1'b0;
    chk("period", k, nxt);
    chk("sweep_n", sd_n, mslot == 5);
    if (mslot == 5) chk("sweep_pos", sd_k, nxt - 1);
    mslot = (mslot + 1) % 6;
  endtask
  function automatic int rnd_lat(input bit allow_to);
    return (allow_to && $urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, T));
  endfunction
  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    cnv_cmplt = 1'b0;
    res = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pots", dut_vec, model_vec());
    chk("rst_flags", {strt_cnv, pots_vld, sweep_done, a2d_err}, 4'b0);
    chk("rst_chnnl", chnnl, 3'd1);
    rst_n = 1'b1;
    wait_strt(k0);
    chk("first_strt", k0, 1);
    c0 = cyc;
    for (int s = 0; s < 6; s++) conv(10, 12'(s * 12'h111), 1'b0);
    chk("sweep_period", cyc - c0, 6 * (1 + 9 + 1 + G));
    chk("B3_sweep1", B3_pot, 12'h333);
    chk("VOL_sweep1", VOL_pot, 12'h555);
    chk("vld_sweep1", pots_vld, 1'b1);
    for (int s = 0; s < 6; s++) conv(s == 3 ? T : rnd_lat(1'b0), s == 3 ? 12'h0AB : 12'($urandom), s == 1);
    chk("coinc_B3", B3_pot, 12'h0AB);
    chk("coinc_err", a2d_err, 1'b0);
    for (int s = 0; s < 3; s++) conv(rnd_lat(1'b0), 12'($urandom), 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_pots", dut_vec, model_vec());
    chk("midrst_flags", {strt_cnv, pots_vld, a2d_err}, 3'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cnv_cmplt = 1'b1;
    res = 12'hFFF;
    @(negedge clk);
    chk("midrst_strt", strt_cnv, 1'b1);
    chk("midrst_chnnl", chnnl, 3'd1);
    cnv_cmplt = 1'b0;
    for (int s = 0; s < 6; s++) conv(s == 2 ? 0 : 10, 12'($urandom), 1'b0);
    chk("to_B2", B2_pot, 12'h800);
    chk("to_vld", pots_vld, 1'b0);
    chk("to_err", a2d_err, 1'b1);
    for (int s = 0; s < 12; s++) conv(rnd_lat(1'b1), 12'($urandom), $urandom_range(0, 1) == 1);
    chk("final_vld", pots_vld, &mseen);
    chk("final_pots", dut_vec, model_vec());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
